arb8way16: RTL
==============

Name: arb8way16

Overview:
- Round-robin arbiter and output stage that shares one 16-bit 8-way selection datapath (an 8-way/16-bit mux) among eight requesters.
- Each cycle it picks one pending requester, drives the mux select, registers the selected word, and presents it downstream on a valid/ready handshake.
- It sits between the eight producer channels and a single 16-bit consumer, e.g. a shared bus or register-file write port.

Parameters:
- WIDTH, 16, data width of each input channel and of out; the block is built and tested at 16 only.
- RST_PTR, 7, reset value of the last-granted pointer; 7 makes channel 0 highest priority after reset.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  8  request per channel; bit i belongs to channel i.
- a..h  input  16 each  channel data 0..7; held stable while the matching req bit is high.
- gnt  output  8  one-hot grant; one-cycle pulse per accepted word.
- out  output  16  registered selected data.
- out_sel  output  3  index of the channel whose word is in out.
- out_valid  output  1  out holds a word not yet taken.
- out_ready  input  1  consumer accepts out this cycle.

Behaviour:
- Reset, sampled on the clock edge:
  - out=0, out_sel=0, out_valid=0, gnt=0, ptr=RST_PTR.
  - A reset mid-transfer discards the held word without asserting gnt or out_valid.
- Load condition: load = (~out_valid | out_ready) & (|req).
- Winner: first channel with req=1, searching (ptr+1), (ptr+2) ... wrapping modulo 8 through 7→0. This search and the data selection are combinational.
- On a load edge:
  - out <= data of the winner.
  - out_sel <= winner index.
  - out_valid <= 1.
  - ptr <= winner index.
  - gnt is one-hot on the winner for exactly that cycle.
- gnt is combinational from the same-cycle load decision.
  - A requester seeing gnt[i]=1 at an edge treats its word as consumed.
  - It either drops req or presents its next word in the following cycle.
- No load and out_valid & out_ready: out_valid <= 0. out and out_sel keep their last values.
- Otherwise all registers hold, and gnt=0.
- Throughput and latency:
  - Full rate, one word per cycle, while out_ready stays high and any req is pending.
  - Latency from grant edge to out_valid is 1 cycle.
- Backpressure: while out_valid=1 and out_ready=0:
  - out, out_sel and out_valid are stable.
  - gnt=0 and ptr holds.
  - No req/data change upstream can alter out.
- Fairness:
  - A continuously requesting channel is granted at least once in every 8 grants.
  - With all req=1, the grant order is 0,1,...,7,0,...
- Single requester: the same channel is granted every eligible cycle.
- req=0: no grant and ptr unchanged. Neither ptr nor out_sel ever changes without a grant.
- out_ready while out_valid=0 is a don't-care and is harmless.
- A mux select stays registered; there is no combinational path from req or data to out.

Test Plan:
- Reset and idle: assert reset 2 cycles with req=8'hFF. Required: out=0, out_valid=0, gnt=0. Release reset with req=0 for 3 cycles. Required: nothing changes.
- Full round-robin:
  - Stimulus: a..h = 16'h1234, 2345, 3456, 4567, 5678, 6789, 789A, 89AB; req=8'hFF; out_ready=1.
  - Required: gnt walks 01,02,04,...,80,01. On each following cycle out matches that channel's value and out_sel=0..7. out_valid stays 1 throughout.
- Sparse and wrap:
  - Stimulus: req=8'b1000_0100 with ptr at 2, held across grants, out_ready=1.
  - Required: grants alternate ch7, ch2, ch7. Outputs are 16'h89AB, 16'h3456, 16'h89AB.
- Backpressure:
  - Stimulus: out_ready=0 after the first grant (ch0, 16'h1234), for 4 cycles, with req=8'hFF.
  - Required: gnt=0, out=16'h1234, out_valid=1 throughout.
  - Then out_ready=1. Required: ch1 is granted in the same cycle, and out=16'h2345 on the next cycle.
- Single requester drains: req=8'h10 for 3 cycles with out_ready=1, then req=0. Required:
  - 3 grants to ch4, each with out=16'h5678.
  - out_valid falls one cycle after the last accept.
- Reset mid-operation: assert reset while out_valid=1 and out_ready=0. Required:
  - out_valid=0 and out=0 on the next cycle.
  - The first grant after reset goes to the lowest-index requester (ptr=7).

Source files
------------

// File: rtl/arb8way16.sv
// arb8way16 - eight-way round-robin arbiter with a registered 16-bit output stage.
//
// Picks one pending requester per cycle, starting the search just after the
// channel granted last, muxes its word into a register and offers it to a
// single consumer on a valid/ready handshake.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   req[7:0]   per-channel request, bit i belongs to channel i
//   a..h       channel 0..7 data, held stable while the matching req is high
//   gnt[7:0]   one-hot grant, pulses in the cycle a word is loaded
//   out        registered selected word
//   out_sel    index of the channel whose word is in out
//   out_valid  out holds a word not yet taken
//   out_ready  consumer accepts out this cycle
module arb8way16 #(
    parameter int WIDTH   = 16,
    parameter int RST_PTR = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       req,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] e,
    input  logic [WIDTH-1:0] f,
    input  logic [WIDTH-1:0] g,
    input  logic [WIDTH-1:0] h,
    output logic [7:0]       gnt,
    output logic [WIDTH-1:0] out,
    output logic [2:0]       out_sel,
    output logic             out_valid,
    input  logic             out_ready
);

    logic [2:0]       ptr;
    logic [2:0]       winner;
    logic [2:0]       idx;
    logic             found;
    logic             load;
    logic [WIDTH-1:0] sel_data;

    // Search ptr+1 .. ptr+8 (mod 8); the last probe is ptr itself, so the
    // last-granted channel has the lowest priority.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int unsigned k = 1; k <= 8; k++) begin
            idx = ptr + 3'(k);
            if (!found && req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        sel_data = '0;
        case (winner)
            3'd0: sel_data = a;
            3'd1: sel_data = b;
            3'd2: sel_data = c;
            3'd3: sel_data = d;
            3'd4: sel_data = e;
            3'd5: sel_data = f;
            3'd6: sel_data = g;
            3'd7: sel_data = h;
            default: sel_data = '0;
        endcase
    end

    // Reset suppresses the load so no grant escapes while the stage clears.
    assign load = ~reset & (~out_valid | out_ready) & (|req);
    assign gnt  = load ? (8'b1 << winner) : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            out       <= '0;
            out_sel   <= '0;
            out_valid <= 1'b0;
            ptr       <= 3'(RST_PTR);
        end else if (load) begin
            out       <= sel_data;
            out_sel   <= winner;
            out_valid <= 1'b1;
            ptr       <= winner;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
